// File: rtl/sha3_state_serialize_to_48.sv
// Serializes one SHA3 state (25 x 64-bit lanes + 16-bit spare) into 34 words of 48 bits
// over valid/ready, capturing the state at handshake and supporting back-to-back states.
module sha3_state_serialize_to_48 (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [319:0] isa,     // lane j of each row sits at [64*j +: 64]
    input  logic [319:0] isb,
    input  logic [319:0] isc,
    input  logic [319:0] isd,
    input  logic [319:0] ise,
    input  logic [15:0]  ispare,
    input  logic         ivalid,
    output logic         iready,
    output logic [47:0]  odata,
    output logic [5:0]   oindex,
    output logic         olast,
    output logic         ovalid,
    input  logic         oready
);

    localparam int unsigned SR_W     = 1632;
    localparam logic [5:0]  LAST_IDX = 6'd33;
    localparam logic [15:0] PAD      = 16'h0000;

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    state_e            state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [SR_W-1:0]   cap;
    logic              load;
    logic              shift;

    // Image of all 34 words MSB-first: {L, PAD, ispare}, so word k = cap[SR_W-1-48k -: 48].
    always_comb begin
        cap = '0;
        for (int j = 0; j < 5; j++) begin
            cap[SR_W-1-64*j      -: 64] = isa[64*j +: 64];
            cap[SR_W-1-64*(5+j)  -: 64] = isb[64*j +: 64];
            cap[SR_W-1-64*(10+j) -: 64] = isc[64*j +: 64];
            cap[SR_W-1-64*(15+j) -: 64] = isd[64*j +: 64];
            cap[SR_W-1-64*(20+j) -: 64] = ise[64*j +: 64];
        end
        cap[31:16] = PAD;
        cap[15:0]  = ispare;
    end

    assign ovalid = (state_q == SEND);
    assign olast  = ovalid & (cnt_q == LAST_IDX);
    assign oindex = cnt_q;
    assign odata  = ovalid ? sr_q[SR_W-1 -: 48] : 48'h0;
    assign iready = rst_n & ((state_q == IDLE) | (olast & oready));

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ivalid && iready) begin
                    load    = 1'b1;
                    cnt_d   = 6'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (oready) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d = 6'd0;
                        if (ivalid) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                        shift = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 6'd0;
            end
        endcase
    end

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = cap;
        end else if (shift) begin
            sr_d = {sr_q[SR_W-49:0], 48'h0};
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: the wide data register is deliberately not reset; odata is gated by ovalid instead.
    always_ff @(posedge clk) begin
        sr_q <= sr_d;
    end

    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= LAST_IDX);

    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (ovalid && !oready) |=> (ovalid && $stable(odata) && $stable(oindex)));

endmodule

// File: tb/tb_sha3_state_serialize_to_48.sv
// Scoreboard bench for sha3_state_serialize_to_48: layout, back-to-back, isolation,
// backpressure, mid-stream reset and a 1000-state collector/merge round trip.
module tb_sha3_state_serialize_to_48;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [319:0] isa, isb, isc, isd, ise;
    logic [15:0]  ispare;
    logic         ivalid;
    logic         iready;
    logic [47:0]  odata;
    logic [5:0]   oindex;
    logic         olast;
    logic         ovalid;
    logic         oready;

    sha3_state_serialize_to_48 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .isa    (isa),
        .isb    (isb),
        .isc    (isc),
        .isd    (isd),
        .ise    (ise),
        .ispare (ispare),
        .ivalid (ivalid),
        .iready (iready),
        .odata  (odata),
        .oindex (oindex),
        .olast  (olast),
        .ovalid (ovalid),
        .oready (oready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [47:0] data;
        logic [5:0]  idx;
        logic        last;
    } exp_t;

    exp_t            sb[$];
    logic [1615:0]   stq[$];     // {spare, lanes} per state for the round trip
    int              n_cmp  = 0;
    int              n_fail = 0;
    bit              bp_mode = 1'b0;
    logic [47:0]     obs[34];
    logic [1631:0]   collect = '0;
    int              run = 0;
    int              last_run = 0;
    bit              hold_pending = 1'b0;
    logic [47:0]     held_data;
    logic [5:0]      held_idx;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Lane g counted from a0 (g=0) to e4 (g=24); bit walk from the MSB of L.
    function automatic logic [47:0] model_word(input logic [1599:0] flat, input logic [15:0] sp,
                                               input int k);
        logic [47:0] w;
        int g;
        if (k == 33) return {flat[64*24 +: 16], 16'h0000, sp};
        for (int b = 0; b < 48; b++) begin
            g    = 48*k + 47 - b;
            w[b] = flat[64*(g/64) + 63 - (g%64)];
        end
        return w;
    endfunction

    function automatic logic [1599:0] rand_lanes();
        logic [1599:0] f;
        for (int i = 0; i < 50; i++) f[32*i +: 32] = $urandom;
        return f;
    endfunction

    task automatic drive(input logic [1599:0] flat, input logic [15:0] sp);
        for (int j = 0; j < 5; j++) begin
            isa[64*j +: 64] = flat[64*j        +: 64];
            isb[64*j +: 64] = flat[64*(5+j)    +: 64];
            isc[64*j +: 64] = flat[64*(10+j)   +: 64];
            isd[64*j +: 64] = flat[64*(15+j)   +: 64];
            ise[64*j +: 64] = flat[64*(20+j)   +: 64];
        end
        ispare = sp;
    endtask

    task automatic push_expected(input logic [1599:0] flat, input logic [15:0] sp);
        exp_t e;
        for (int k = 0; k < 34; k++) begin
            e.data = model_word(flat, sp, k);
            e.idx  = 6'(k);
            e.last = (k == 33);
            sb.push_back(e);
        end
        stq.push_back({sp, flat});
    endtask

    // Called at posedge+1; returns at posedge+1 one cycle after the handshake edge.
    task automatic send_state(input logic [1599:0] flat, input logic [15:0] sp, input bit scramble);
        bit done = 1'b0;
        drive(flat, sp);
        ivalid = 1'b1;
        for (int t = 0; t < 1000 && !done; t++) begin
            @(negedge clk);
            if (iready && ivalid) begin
                push_expected(flat, sp);
                done = 1'b1;
            end
        end
        if (!done) check("handshake_timeout", 64'(done), 64'(1));
        @(posedge clk); #1;
        ivalid = 1'b0;
        if (scramble) begin
            repeat (40) begin
                drive(rand_lanes(), 16'($urandom));
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int t = 0; t < 2000 && !done; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && !ovalid) done = 1'b1;
        end
        if (!done) check("drain_timeout", 64'(sb.size()), 64'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        oready = 1'b1;
        forever begin
            @(posedge clk); #1;
            oready = bp_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    // Monitor: a word is accepted at the next rising edge when ovalid & oready here.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pending = 1'b0;
            run          = 0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", 64'(ovalid), 64'(1));
                check("hold_data",  64'(odata),  64'(held_data));
                check("hold_index", 64'(oindex), 64'(held_idx));
            end
            hold_pending = ovalid && !oready;
            held_data    = odata;
            held_idx     = oindex;

            if (ovalid) run++;
            else if (run != 0) begin
                last_run = run;
                run      = 0;
            end

            if (ovalid && oready) begin
                if (sb.size() == 0) begin
                    check("unexpected_word", 64'(sb.size()), 64'(1));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("odata",  64'(odata),  64'(e.data));
                    check("oindex", 64'(oindex), 64'(e.idx));
                    check("olast",  64'(olast),  64'(e.last));
                    obs[oindex] = odata;
                    collect = {collect[1583:0], odata};
                    if (e.last && stq.size() != 0) begin
                        logic [1615:0] st;
                        st = stq.pop_front();
                        for (int j = 0; j < 25; j++)
                            check("rt_lane", collect[1631-64*j -: 64], st[64*j +: 64]);
                        check("rt_spare", 64'(collect[15:0]), 64'(st[1615:1600]));
                    end
                end
            end else if (!ovalid) begin
                check("idle_olast", 64'(olast), 64'(0));
            end
        end
    end

    initial begin
        logic [1599:0] flat;
        bit found;

        rst_n  = 1'b0;
        ivalid = 1'b0;
        drive('0, 16'h0);
        #3;
        check("rst_ovalid", 64'(ovalid), 64'(0));
        check("rst_olast",  64'(olast),  64'(0));
        check("rst_odata",  64'(odata),  64'(0));
        check("rst_oindex", 64'(oindex), 64'(0));
        check("rst_iready", 64'(iready), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_iready", 64'(iready), 64'(1));
        @(posedge clk); #1;

        // Layout pattern
        for (int i = 0; i < 25; i++) flat[64*i +: 64] = 64'h0101010101010101 * 64'(i);
        send_state(flat, 16'hBEEF, 1'b0);
        drain();
        check("layout_word1",  64'(obs[1]),  64'h0000_0000_0101_0101);
        check("layout_word33", 64'(obs[33]), 64'h0000_1818_0000_BEEF);

        // Back-to-back: two states with ivalid held high
        send_state(rand_lanes(), 16'($urandom), 1'b0);
        send_state(rand_lanes(), 16'($urandom), 1'b0);
        drain();
        check("b2b_valid_run", 64'(last_run), 64'(68));

        // Input isolation
        for (int s = 0; s < 3; s++) send_state(rand_lanes(), 16'($urandom), 1'b1);
        drain();

        // Backpressure at 30% ready
        bp_mode = 1'b1;
        for (int s = 0; s < 30; s++) send_state(rand_lanes(), 16'($urandom), 1'b0);
        drain();
        bp_mode = 1'b0;
        @(posedge clk); #1;

        // Reset while streaming word 17
        send_state(rand_lanes(), 16'($urandom), 1'b0);
        found = 1'b0;
        for (int t = 0; t < 200 && !found; t++) begin
            @(negedge clk);
            if (ovalid && oindex == 6'd17) found = 1'b1;
        end
        check("reach_word17", 64'(found), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ovalid", 64'(ovalid), 64'(0));
        check("midrst_olast",  64'(olast),  64'(0));
        check("midrst_odata",  64'(odata),  64'(0));
        check("midrst_oindex", 64'(oindex), 64'(0));
        check("midrst_iready", 64'(iready), 64'(0));
        sb.delete();
        stq.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("post_midrst_ovalid", 64'(ovalid), 64'(0));
            check("post_midrst_iready", 64'(iready), 64'(1));
        end
        @(posedge clk); #1;

        // Round trip: 1000 random states
        for (int s = 0; s < 1000; s++) send_state(rand_lanes(), 16'($urandom), 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
